// File: rtl/cmul_sched_pkg.sv
// cmul_sched_pkg: shared constants and types for the twiddle-multiplier scheduler.
//   N_DEF     data width exponent (data width W = 2**N)
//   W_DEF     default data width
//   NREQ_DEF  default number of requesters
//   LAT_DEF   register stages inside the shared multiplier
//   IDW       requester id width
//   tag_t     in-flight tag record {valid, id}
// The tag id width follows NREQ_DEF; change NREQ_DEF here when building
// for a different requester count.
package cmul_sched_pkg;

    localparam int N_DEF    = 4;
    localparam int W_DEF    = 2**N_DEF;
    localparam int NREQ_DEF = 4;
    localparam int LAT_DEF  = 2;
    localparam int IDW      = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: single-grant arbiter for the shared multiplier.
//   Build option CMUL_SCHED_RR_EN:
//     defined   -> round-robin; search starts at pointer+1 (mod NREQ), the
//                  pointer moves to the granted index on every grant and
//                  resets to NREQ-1 so requester 0 wins first.
//     undefined -> fixed priority, lowest index wins; no pointer state.
// Ports:
//   clk        clock (round-robin build only)
//   rst        synchronous active-low reset; grant forced to zero while low
//   i_req      per-requester request
//   o_gnt      one-hot grant, combinational
//   o_gnt_id   index of the granted requester (0 when none)
//   o_gnt_vld  any grant this cycle
module rr_arbiter
    import cmul_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
`ifdef CMUL_SCHED_RR_EN
    input  logic            clk,
`endif
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_gnt_vld
);

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_found;
    logic [IDW-1:0]  w_idx;

`ifdef CMUL_SCHED_RR_EN
    logic [IDW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (w_found) begin
            r_ptr <= w_gnt_id;
        end
    end

    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        if (rst) begin
            // Offsets 1..NREQ visit every requester once, the pointer's own
            // index last, so the most recent winner has lowest priority.
            for (int off = 1; off <= NREQ; off++) begin
                w_idx = IDW'((int'(r_ptr) + off) % NREQ);
                if (!w_found && i_req[w_idx]) begin
                    w_gnt[w_idx] = 1'b1;
                    w_gnt_id     = w_idx;
                    w_found      = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                w_idx = IDW'(i);
                if (!w_found && i_req[w_idx]) begin
                    w_gnt[w_idx] = 1'b1;
                    w_gnt_id     = w_idx;
                    w_found      = 1'b1;
                end
            end
        end
    end
`endif

    assign o_gnt     = w_gnt;
    assign o_gnt_id  = w_gnt_id;
    assign o_gnt_vld = w_found;

endmodule

// File: rtl/cmul_sched.sv
// cmul_sched: shares one pipelined 1/sqrt2 shift-add multiplier among NREQ
// butterfly requesters. Arbitrates, drives the registered multiplier operand,
// carries a tag alongside each operation and returns the product to the
// requester that issued it, LAT+2 cycles after its grant.
// Build option CMUL_SCHED_RR_EN selects round-robin arbitration (defined) or
// fixed lowest-index priority (undefined); timing is identical in both.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   req         per-requester request, held until granted
//   req_data    packed operands, requester i at [i*W +: W]
//   gnt         one-hot grant, combinational
//   mul_a       registered operand to the shared multiplier
//   mul_result  multiplier output, valid LAT cycles after mul_a
//   rsp_valid   one-hot response strobe, one cycle wide
//   rsp_data    registered product (holds when rsp_valid is 0)
//   busy        any operation in flight
//
// Handshake: an operation transfers in the cycle where req[i] & gnt[i]; the
// requester keeps req[i] and its operand stable until then and drops or
// renews req the following cycle. Responses have no backpressure.
module cmul_sched
    import cmul_sched_pkg::*;
#(
    parameter  int N    = N_DEF,
    parameter  int NREQ = NREQ_DEF,
    parameter  int LAT  = LAT_DEF,
    localparam int W    = 2**N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      mul_a,
    input  logic [W-1:0]      mul_result,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              busy
);

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_gnt_vld;
    logic [W-1:0]    w_ops [NREQ];
    logic            w_tag_busy;

    tag_t            r_tag [LAT+1];
    logic [W-1:0]    r_mul_a;
    logic [NREQ-1:0] r_rsp_valid;
    logic [W-1:0]    r_rsp_data;

    rr_arbiter #(
        .NREQ      (NREQ)
    ) u_arb (
`ifdef CMUL_SCHED_RR_EN
        .clk       (clk),
`endif
        .rst       (rst),
        .i_req     (req),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_vld (w_gnt_vld)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign w_ops[g] = req_data[g*W +: W];
    end

    // r_tag[k] travels with the operand that entered the multiplier k cycles
    // ago; r_tag[LAT] lines up with mul_result, so no stall logic is needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k <= LAT; k++) begin
                r_tag[k] <= '0;
            end
            r_mul_a     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_tag[0] <= tag_t'{valid: w_gnt_vld, id: w_gnt_id};
            for (int k = 1; k <= LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            r_mul_a <= w_gnt_vld ? w_ops[w_gnt_id] : '0;
            if (r_tag[LAT].valid) begin
                r_rsp_valid <= NREQ'(1) << r_tag[LAT].id;
                r_rsp_data  <= mul_result;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    always_comb begin
        w_tag_busy = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            w_tag_busy = w_tag_busy | r_tag[k].valid;
        end
    end

    assign gnt       = w_gnt;
    assign mul_a     = r_mul_a;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = w_tag_busy | (|r_rsp_valid);

endmodule

// File: tb/tb_cmul_sched.sv
// tb_cmul_sched: directed bench for cmul_sched with an external multiplier
// model (a>>1 + a>>3 + a>>4 + a>>6 + a>>8, LAT register stages).
// Honours CMUL_SCHED_RR_EN for the arbitration expectations.
module tb_cmul_sched;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic [NREQ-1:0]   req      = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_result;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cmul_sched #(
        .N          (N),
        .NREQ       (NREQ),
        .LAT        (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .mul_a      (mul_a),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- external multiplier model ----------------
    function automatic logic [W-1:0] mulf(input logic [W-1:0] a);
        return (a >> 1) + (a >> 3) + (a >> 4) + (a >> 6) + (a >> 8);
    endfunction

    logic [W-1:0] mpipe [LAT];
    initial begin
        for (int k = 0; k < LAT; k++) mpipe[k] = '0;
    end
    always @(posedge clk) begin
        mpipe[0] <= mulf(mul_a);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = mpipe[LAT-1];

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    // Arbitration rule: first requesting index scanning upward from the one
    // after the last winner (round-robin) or from index 0 (fixed priority).
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
`ifdef CMUL_SCHED_RR_EN
            int i = (last + k) % NREQ;
`else
            int i = k - 1;
`endif
            if (r[i]) return i;
        end
        return -1;
    endfunction

    logic [W-1:0]    exp_q[$];
    int              exp_id_q[$];
    int              exp_due_q[$];
    logic [W-1:0]    exp_mul_a = '0;
    logic [W-1:0]    last_rd   = '0;
    int              m_last    = NREQ - 1;
    logic [NREQ-1:0] one_n     = 1;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_rv;
        logic [W-1:0]    e_rd;
        logic [NREQ-1:0] e_g;
        logic [W-1:0]    op;
        logic            e_busy;
        int              w;

        // An op is in flight from the cycle after its grant until its
        // response cycle inclusive.
        e_busy = (exp_due_q.size() != 0);
        e_rv   = '0;
        e_rd   = last_rd;
        if (exp_due_q.size() != 0 && exp_due_q[0] == cyc) begin
            e_rv    = one_n << exp_id_q[0];
            e_rd    = exp_q[0];
            last_rd = exp_q[0];
            void'(exp_q.pop_front());
            void'(exp_id_q.pop_front());
            void'(exp_due_q.pop_front());
        end
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("rsp_data",  32'(rsp_data),  32'(e_rd));
        check("mul_a",     32'(mul_a),     32'(exp_mul_a));
        check("busy",      32'(busy),      32'(e_busy));

        w   = rst ? pick(req, m_last) : -1;
        e_g = (w >= 0) ? (one_n << w) : '0;
        check("gnt", 32'(gnt), 32'(e_g));

        if (!rst) begin
            exp_q.delete();
            exp_id_q.delete();
            exp_due_q.delete();
            last_rd   = '0;
            exp_mul_a = '0;
            m_last    = NREQ - 1;
        end else if (w >= 0) begin
            op = req_data[w*W +: W];
            exp_q.push_back(mulf(op));
            exp_id_q.push_back(w);
            exp_due_q.push_back(cyc + LAT + 2);
            exp_mul_a = op;
            m_last    = w;
        end else begin
            exp_mul_a = '0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        req = '0;
        ticks(n);
        rst = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    // ---------------- directed sequence ----------------
    logic [W-1:0]    rr_prod [4] = '{16'h00B5, 16'h016A, 16'h02D4, 16'h05A8};
    logic [NREQ-1:0] lit_g;

    initial begin
        do_reset(2);
        #1;
        check("reset_rsp_data",  32'(rsp_data),  32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_mul_a",     32'(mul_a),     32'h0);

        // single request, 4-cycle latency
        set_op(0, 16'h4000);
        req = 4'b0001;
        #1 check("single_gnt", 32'(gnt), 32'h1);
        tick();
        req = '0;
        #1 check("single_mul_a", 32'(mul_a), 32'h4000);
        ticks(3);
        #1;
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_data",  32'(rsp_data),  32'h2D40);
        check("single_busy",      32'(busy),      32'h1);
        tick();
        #1;
        check("single_done_valid", 32'(rsp_valid), 32'h0);
        check("single_done_busy",  32'(busy),      32'h0);

        // idle: outputs quiet, product held
        ticks(10);
        #1;
        check("idle_gnt",      32'(gnt),      32'h0);
        check("idle_mul_a",    32'(mul_a),    32'h0);
        check("idle_rsp_data", 32'(rsp_data), 32'h2D40);

        // all four requesting for 8 cycles
        do_reset(1);
        set_op(0, 16'h0100);
        set_op(1, 16'h0200);
        set_op(2, 16'h0400);
        set_op(3, 16'h0800);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
`ifdef CMUL_SCHED_RR_EN
            lit_g = 4'b0001 << (k % 4);
            check("all_gnt", 32'(gnt), 32'(lit_g));
            if (k >= 4) begin
                lit_g = 4'b0001 << (k - 4);
                check("all_rsp_valid", 32'(rsp_valid), 32'(lit_g));
                check("all_rsp_data",  32'(rsp_data),  32'(rr_prod[k-4]));
            end
`else
            check("all_gnt", 32'(gnt), 32'h1);
            if (k >= 4) begin
                check("all_rsp_valid", 32'(rsp_valid), 32'h1);
                check("all_rsp_data",  32'(rsp_data),  32'(rr_prod[0]));
            end
`endif
            tick();
        end
        req = '0;
        ticks(6);

        // requesters 1 and 3
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
`ifdef CMUL_SCHED_RR_EN
            lit_g = (k == 1) ? 4'b1000 : 4'b0010;
`else
            lit_g = 4'b0010;
`endif
            check("pair_gnt", 32'(gnt), 32'(lit_g));
            tick();
        end
        req = '0;
        ticks(5);

        // pointer wrap: grant 3, then 0 and 3 compete
        req = 4'b1000;
        #1 check("wrap_gnt3", 32'(gnt), 32'h8);
        tick();
        req = 4'b1001;
        #1 check("wrap_gnt0", 32'(gnt), 32'h1);
        tick();
        req = '0;
        ticks(5);

        // reset while two ops are in flight
        req = 4'b0011;
        tick();
        tick();
        req = '0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("flush_busy",      32'(busy),      32'h0);
        check("flush_rsp_valid", 32'(rsp_valid), 32'h0);
        check("flush_rsp_data",  32'(rsp_data),  32'h0);
        tick();
        #1 check("flush_late_valid", 32'(rsp_valid), 32'h0);

        // normal op after the flush
        set_op(2, 16'h1234);
        req = 4'b0100;
        #1 check("post_gnt", 32'(gnt), 32'h4);
        tick();
        req = '0;
        ticks(3);
        #1;
        check("post_rsp_valid", 32'(rsp_valid), 32'h4);
        check("post_rsp_data",  32'(rsp_data),  32'h0CDD);
        ticks(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
